disp_fmt: RTL and testbench

Display formatter directly upstream of the seven-segment serial interface. It captures the current hour/minute/second and the edit mode, and converts each binary field to two BCD digits with a sequential shift-add-3 converter. It presents six digits, a per-digit twinkle mask and a per-digit decimal-point mask, then strobes `valid_sd` so the serial interface reloads its frame. It also re-strobes periodically so the display refreshes when the time is unchanged.

---
 rtl/disp_fmt_pkg.sv | 35 +++
 rtl/disp_fmt_bin2bcd6_seq.sv | 39 +++
 rtl/disp_fmt.sv | 147 ++++++++++++++
 tb/tb_disp_fmt.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_fmt_pkg.sv
// Shared constants and types for the display formatter: FSM states, edit-mode codes,
// refresh default and twinkle masks.
package disp_fmt_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StConv,
      StOut
   } state_t;

   localparam logic [1:0] ModeRun  = 2'd0;
   localparam logic [1:0] ModeHour = 2'd1;
   localparam logic [1:0] ModeMin  = 2'd2;
   localparam logic [1:0] ModeSec  = 2'd3;

   localparam int unsigned RefreshCycDefault = 50_000;
   localparam logic [2:0]  LastStep          = 3'd5;

   localparam logic [5:0] TwinkleNone = 6'b000000;
   localparam logic [5:0] TwinkleHour = 6'b110000;
   localparam logic [5:0] TwinkleMin  = 6'b001100;
   localparam logic [5:0] TwinkleSec  = 6'b000011;

   function automatic logic [5:0] twinkle_mask(input logic [1:0] mode);
      logic [5:0] mask;
      unique case (mode)
         ModeHour: mask = TwinkleHour;
         ModeMin:  mask = TwinkleMin;
         ModeSec:  mask = TwinkleSec;
         default:  mask = TwinkleNone;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/disp_fmt_bin2bcd6_seq.sv
// 6-bit sequential double-dabble: load captures the binary value, each shift performs
// one add-3-then-shift step. Six shifts leave the result on tens_o/units_o.
module bin2bcd6_seq (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic       shift_i,
   input  logic [5:0] bin_i,
   output logic [3:0] tens_o,
   output logic [3:0] units_o
);

   logic [5:0] bin_q;
   logic [3:0] tens_q, units_q;
   logic [3:0] tens_adj, units_adj;

   always_comb begin
      tens_adj  = (tens_q  >= 4'd5) ? tens_q  + 4'd3 : tens_q;
      units_adj = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bin_q   <= '0;
         tens_q  <= '0;
         units_q <= '0;
      end else if (load_i) begin
         bin_q   <= bin_i;
         tens_q  <= '0;
         units_q <= '0;
      end else if (shift_i) begin
         {tens_q, units_q, bin_q} <= {tens_adj[2:0], units_adj, bin_q, 1'b0};
      end
   end

   assign tens_o  = tens_q;
   assign units_o = units_q;

endmodule

// File: rtl/disp_fmt.sv
// Display formatter: captures time and edit mode, converts to six BCD digits and
// strobes valid_sd with twinkle/decimal-point masks; re-strobes after REFRESH_CYC idle cycles.
module disp_fmt
   import disp_fmt_pkg::*;
#(
   parameter int unsigned REFRESH_CYC = RefreshCycDefault
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       time_upd,
   input  logic [4:0] hour,
   input  logic [5:0] minute,
   input  logic [5:0] second,
   input  logic [1:0] set_mode,
   input  logic       alarm_on,
   output logic [3:0] num6,
   output logic [3:0] num5,
   output logic [3:0] num4,
   output logic [3:0] num3,
   output logic [3:0] num2,
   output logic [3:0] num1,
   output logic [5:0] twinkle,
   output logic [5:0] dp,
   output logic       valid_sd,
   output logic       busy
);

   localparam int unsigned CntW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

   state_t          state_q, state_d;
   logic [2:0]      step_q, step_d;
   logic            pend_q, pend_d;
   logic [CntW-1:0] ref_cnt_q, ref_cnt_d;
   logic [1:0]      mode_sh;
   logic            alarm_sh;
   logic            ref_term, req, load, shift, out_en;
   logic [3:0]      hour_t, hour_u, min_t, min_u, sec_t, sec_u;

   assign ref_term = (ref_cnt_q == CntW'(REFRESH_CYC - 1));
   assign req      = time_upd | (set_mode != mode_sh) | (alarm_on != alarm_sh) | ref_term;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      pend_d  = pend_q;
      load    = 1'b0;
      shift   = 1'b0;
      out_en  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req || pend_q) begin
               state_d = StConv;
               step_d  = 3'd0;
               pend_d  = 1'b0;
               load    = 1'b1;
            end
         end
         StConv: begin
            shift  = 1'b1;
            step_d = step_q + 3'd1;
            if (req) pend_d = 1'b1;
            if (step_q == LastStep) state_d = StOut;
         end
         StOut: begin
            out_en  = 1'b1;
            state_d = StIdle;
            if (req) pend_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   // Refresh measures time since the last frame, so a strobe restarts the count.
   always_comb begin
      if (valid_sd || ref_term) ref_cnt_d = '0;
      else                      ref_cnt_d = ref_cnt_q + CntW'(1);
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         step_q    <= '0;
         pend_q    <= 1'b0;
         ref_cnt_q <= '0;
         mode_sh   <= '0;
         alarm_sh  <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         pend_q    <= pend_d;
         ref_cnt_q <= ref_cnt_d;
         if (load) begin
            mode_sh  <= set_mode;
            alarm_sh <= alarm_on;
         end
      end
   end

   bin2bcd6_seq u_hour (
      .clk_i   (sysclk),
      .rst_ni  (rst_n),
      .load_i  (load),
      .shift_i (shift),
      .bin_i   ({1'b0, hour}),
      .tens_o  (hour_t),
      .units_o (hour_u)
   );

   bin2bcd6_seq u_min (
      .clk_i   (sysclk),
      .rst_ni  (rst_n),
      .load_i  (load),
      .shift_i (shift),
      .bin_i   (minute),
      .tens_o  (min_t),
      .units_o (min_u)
   );

   bin2bcd6_seq u_sec (
      .clk_i   (sysclk),
      .rst_ni  (rst_n),
      .load_i  (load),
      .shift_i (shift),
      .bin_i   (second),
      .tens_o  (sec_t),
      .units_o (sec_u)
   );

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         {num6, num5, num4, num3, num2, num1} <= '0;
         twinkle  <= '0;
         dp       <= '0;
         valid_sd <= 1'b0;
      end else begin
         valid_sd <= out_en;
         if (out_en) begin
            {num6, num5, num4, num3, num2, num1} <= {hour_t, hour_u, min_t, min_u, sec_t, sec_u};
            twinkle <= twinkle_mask(mode_sh);
            dp      <= {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, alarm_sh};
         end
      end
   end

   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_disp_fmt.sv
// Scoreboard bench for disp_fmt: expected frames are queued as stimulus is driven and
// compared whenever valid_sd strobes.
module tb_disp_fmt;

   typedef struct {
      logic [23:0] digits;
      logic [5:0]  tw;
      logic [5:0]  dp;
   } frame_t;

   logic       sysclk;
   logic       rst_n;
   logic       time_upd;
   logic [4:0] hour;
   logic [5:0] minute, second;
   logic [1:0] set_mode;
   logic       alarm_on;
   logic [3:0] num6, num5, num4, num3, num2, num1;
   logic [5:0] twinkle, dp;
   logic       valid_sd, busy;

   int     n_checks = 0;
   int     n_pass   = 0;
   int     cyc      = 0;
   logic   prev_valid = 1'b0;
   frame_t exp_q[$];
   int     strobe_q[$];

   disp_fmt #(.REFRESH_CYC(20)) dut (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .time_upd (time_upd),
      .hour     (hour),
      .minute   (minute),
      .second   (second),
      .set_mode (set_mode),
      .alarm_on (alarm_on),
      .num6     (num6),
      .num5     (num5),
      .num4     (num4),
      .num3     (num3),
      .num2     (num2),
      .num1     (num1),
      .twinkle  (twinkle),
      .dp       (dp),
      .valid_sd (valid_sd),
      .busy     (busy)
   );

   initial begin
      sysclk = 1'b0;
      forever #5 sysclk = ~sysclk;
   end

   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic frame_t mk(input int h, input int m, input int s,
                                 input logic [1:0] mode, input logic al);
      frame_t f;
      f.digits = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
      case (mode)
         2'd1:    f.tw = 6'b110000;
         2'd2:    f.tw = 6'b001100;
         2'd3:    f.tw = 6'b000011;
         default: f.tw = 6'b000000;
      endcase
      f.dp = {5'b01010, al};
      return f;
   endfunction

   always @(negedge sysclk) begin
      if (valid_sd === 1'b1) begin
         frame_t f;
         strobe_q.push_back(cyc);
         check("strobe_width", {31'd0, prev_valid}, 0);
         if (exp_q.size() == 0) begin
            check("extra_strobe", {31'd0, valid_sd}, 0);
         end else begin
            f = exp_q.pop_front();
            check("digits", {8'd0, num6, num5, num4, num3, num2, num1}, {8'd0, f.digits});
            check("twinkle", {26'd0, twinkle}, {26'd0, f.tw});
            check("dp", {26'd0, dp}, {26'd0, f.dp});
         end
      end
      prev_valid <= valid_sd;
   end

   task automatic wait_strobes(input string tag, input int target, input int budget);
      int n = 0;
      while (strobe_q.size() < target && n < budget) begin
         @(negedge sysclk);
         n++;
      end
      check(tag, strobe_q.size(), target);
   endtask

   // Drives a one-cycle time_upd; c is the cycle count before the sampling edge.
   task automatic pulse_upd(input int h, input int m, input int s, output int c);
      hour     = 5'(h);
      minute   = 6'(m);
      second   = 6'(s);
      time_upd = 1'b1;
      c        = cyc;
      @(negedge sysclk);
      time_upd = 1'b0;
   endtask

   initial begin
      int c, base;
      rst_n    = 1'b0;
      time_upd = 1'b0;
      hour     = '0;
      minute   = '0;
      second   = '0;
      set_mode = 2'd0;
      alarm_on = 1'b0;
      repeat (3) @(negedge sysclk);
      check("rst_digits", {8'd0, num6, num5, num4, num3, num2, num1}, 0);
      check("rst_twinkle", {26'd0, twinkle}, 0);
      check("rst_dp", {26'd0, dp}, 0);
      check("rst_valid", {31'd0, valid_sd}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      rst_n = 1'b1;
      @(negedge sysclk);

      // Basic conversion and latency
      exp_q.push_back(mk(23, 59, 7, 2'd0, 1'b0));
      pulse_upd(23, 59, 7, c);
      check("busy_conv", {31'd0, busy}, 1);
      wait_strobes("strobe1", 1, 40);
      check("latency1", strobe_q[strobe_q.size()-1] - (c + 1), 7);

      // Mode/alarm change alone triggers a frame
      base     = strobe_q.size();
      set_mode = 2'd2;
      alarm_on = 1'b1;
      c        = cyc;
      exp_q.push_back(mk(23, 59, 7, 2'd2, 1'b1));
      wait_strobes("strobe_mode", base + 1, 40);
      check("latency_mode", strobe_q[strobe_q.size()-1] - (c + 1), 7);

      // Update mid-conversion: old frame first, pending frame 8 cycles later
      base = strobe_q.size();
      exp_q.push_back(mk(23, 59, 7, 2'd2, 1'b1));
      pulse_upd(23, 59, 7, c);
      repeat (2) @(negedge sysclk);
      exp_q.push_back(mk(23, 59, 45, 2'd2, 1'b1));
      pulse_upd(23, 59, 45, c);
      wait_strobes("strobe_pend", base + 2, 60);
      check("pend_gap", strobe_q[strobe_q.size()-1] - strobe_q[strobe_q.size()-2], 8);
      repeat (12) @(negedge sysclk);
      check("pend_two_only", strobe_q.size(), base + 2);

      // Out-of-range values are displayed unclamped
      base = strobe_q.size();
      exp_q.push_back(mk(31, 63, 45, 2'd2, 1'b1));
      pulse_upd(31, 63, 45, c);
      wait_strobes("strobe_max", base + 1, 40);

      // Reset mid-conversion abandons the frame
      base = strobe_q.size();
      pulse_upd(12, 34, 56, c);
      repeat (3) @(negedge sysclk);
      rst_n    = 1'b0;
      set_mode = 2'd0;
      alarm_on = 1'b0;
      @(negedge sysclk);
      check("mid_rst_digits", {8'd0, num6, num5, num4, num3, num2, num1}, 0);
      check("mid_rst_twinkle", {26'd0, twinkle}, 0);
      check("mid_rst_dp", {26'd0, dp}, 0);
      check("mid_rst_busy", {31'd0, busy}, 0);
      @(negedge sysclk);
      rst_n = 1'b1;
      repeat (10) @(negedge sysclk);
      check("no_strobe_after_rst", strobe_q.size(), base);
      exp_q.push_back(mk(12, 34, 56, 2'd0, 1'b0));
      pulse_upd(12, 34, 56, c);
      wait_strobes("strobe_post_rst", base + 1, 40);
      check("latency_post_rst", strobe_q[strobe_q.size()-1] - (c + 1), 7);

      // Refresh with no input activity: REFRESH_CYC + 8 between frames
      base = strobe_q.size();
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(12, 34, 56, 2'd0, 1'b0));
      wait_strobes("strobe_refresh", base + 3, 120);
      for (int i = 0; i < 3; i++) begin
         if (base + i < strobe_q.size())
            check("refresh_gap", strobe_q[base+i] - strobe_q[base+i-1], 28);
      end

      check("exp_q_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
